hp_ctrl: RTL and testbench

//  Game-logic controller for the player hit-point counter shown by the HP text overlay.

---
 rtl/hp_ctrl_if.sv | 24 ++
 rtl/hp_ctrl.sv | 131 +++++++++++++
 tb/tb_hp_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hp_ctrl_if.sv
// HUD/game-logic bundle for the player HP controller: frame and event inputs, HUD outputs.
interface hp_ctrl_if #(
  parameter int unsigned HP_W = 4
) ();
  logic            vblnk;
  logic            start;
  logic            hit;
  logic            heal;
  logic [HP_W-1:0] hp_out;
  logic            low_hp;
  logic            invuln;
  logic            sprite_vis;
  logic            game_over;

  modport master (
    output vblnk, start, hit, heal,
    input  hp_out, low_hp, invuln, sprite_vis, game_over
  );

  modport slave (
    input  vblnk, start, hit, heal,
    output hp_out, low_hp, invuln, sprite_vis, game_over
  );
endinterface

// File: rtl/hp_ctrl.sv
// Player hit-point controller: latches hit/heal events and applies them once per frame
// at the vblnk rising edge, sequencing idle / play / invulnerable / dead states.
module hp_ctrl #(
  parameter int unsigned HP_MAX        = 9,
  parameter int unsigned HP_W          = 4,
  parameter int unsigned LOW_HP        = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input  logic      clk,
  input  logic      rst,
  hp_ctrl_if.slave  bus
);
  localparam int unsigned INV_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, INVULN, DEAD} state_t;

  state_t           state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic             low_q, low_d;
  logic             invuln_q, invuln_d;
  logic             vis_q, vis_d;
  logic             over_q, over_d;
  logic             hit_pend_q, hit_pend_d;
  logic             heal_pend_q, heal_pend_d;
  logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
  logic [BLK_W-1:0] blink_q, blink_d;
  logic             vblnk_q;
  logic             tick_c;
  logic [HP_W-1:0]  healed_c;

  // State and HUD registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hp_q        <= '0;
      low_q       <= 1'b0;
      invuln_q    <= 1'b0;
      vis_q       <= 1'b1;
      over_q      <= 1'b0;
      hit_pend_q  <= 1'b0;
      heal_pend_q <= 1'b0;
      inv_cnt_q   <= '0;
      blink_q     <= '0;
      vblnk_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      low_q       <= low_d;
      invuln_q    <= invuln_d;
      vis_q       <= vis_d;
      over_q      <= over_d;
      hit_pend_q  <= hit_pend_d;
      heal_pend_q <= heal_pend_d;
      inv_cnt_q   <= inv_cnt_d;
      blink_q     <= blink_d;
      vblnk_q     <= bus.vblnk;
    end
  end

  // Next-state: event latching, frame update, start override
  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    vis_d       = vis_q;
    inv_cnt_d   = inv_cnt_q;
    blink_d     = blink_q;
    tick_c      = bus.vblnk & ~vblnk_q;
    healed_c    = (hp_q >= HP_W'(HP_MAX)) ? HP_W'(HP_MAX) : hp_q + HP_W'(1);
    // Pulses coincident with a tick survive into the next frame
    hit_pend_d  = (tick_c ? 1'b0 : hit_pend_q)  | (bus.hit  & (state_q == PLAY));
    heal_pend_d = (tick_c ? 1'b0 : heal_pend_q) |
                  (bus.heal & ((state_q == PLAY) || (state_q == INVULN)));

    if (bus.start) begin
      state_d     = PLAY;
      hp_d        = HP_W'(HP_MAX);
      hit_pend_d  = 1'b0;
      heal_pend_d = 1'b0;
      inv_cnt_d   = '0;
      blink_d     = '0;
      vis_d       = 1'b1;
    end else if (tick_c) begin
      case (state_q)
        PLAY: begin
          if (hit_pend_q) begin
            if (hp_q <= HP_W'(1)) begin
              hp_d    = '0;
              state_d = DEAD;
            end else begin
              hp_d      = hp_q - HP_W'(1);
              state_d   = INVULN;
              inv_cnt_d = INV_W'(INVULN_FRAMES - 1);
              blink_d   = '0;
              vis_d     = 1'b0;
            end
          end else if (heal_pend_q) begin
            hp_d = healed_c;
          end
        end
        INVULN: begin
          if (heal_pend_q) hp_d = healed_c;
          if (inv_cnt_q == '0) begin
            state_d = PLAY;
            vis_d   = 1'b1;
          end else begin
            inv_cnt_d = inv_cnt_q - INV_W'(1);
            if (blink_q == BLK_W'(BLINK_FRAMES - 1)) begin
              blink_d = '0;
              vis_d   = ~vis_q;
            end else begin
              blink_d = blink_q + BLK_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    low_d    = (hp_d != '0) && (hp_d <= HP_W'(LOW_HP));
    invuln_d = (state_d == INVULN);
    over_d   = (state_d == DEAD);
  end

  assign bus.hp_out     = hp_q;
  assign bus.low_hp     = low_q;
  assign bus.invuln     = invuln_q;
  assign bus.sprite_vis = vis_q;
  assign bus.game_over  = over_q;
endmodule

// File: tb/tb_hp_ctrl.sv
// Self-checking bench for hp_ctrl: frame-level reference model feeding a scoreboard,
// directed scenarios plus randomized event traffic.
module tb_hp_ctrl;
  localparam int unsigned HP_MAX = 9;
  localparam int unsigned HP_W   = 4;
  localparam int unsigned LOW_HP = 3;
  localparam int unsigned INV_F  = 60;
  localparam int unsigned BLK_F  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hp_ctrl_if #(.HP_W(HP_W)) bus ();

  hp_ctrl #(
    .HP_MAX(HP_MAX), .HP_W(HP_W), .LOW_HP(LOW_HP),
    .INVULN_FRAMES(INV_F), .BLINK_FRAMES(BLK_F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int hp;
    bit low;
    bit inv;
    bit vis;
    bit go;
  } exp_t;

  typedef enum {M_IDLE, M_PLAY, M_INV, M_DEAD} mode_t;

  exp_t  sb[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model: game state evaluated per frame
  mode_t m;
  int    hp;
  int    frames_since_hit;
  bit    vis, hit_p, heal_p, v_prev;

  function automatic int sat_heal(input int x);
    return (x + 1 > int'(HP_MAX)) ? int'(HP_MAX) : x + 1;
  endfunction

  task automatic model_step(input bit r, input bit v, input bit s, input bit h, input bit he);
    bit tick, nh, nhe;
    exp_t e;
    if (!r) begin
      m = M_IDLE; hp = 0; vis = 1'b1; hit_p = 1'b0; heal_p = 1'b0; v_prev = 1'b0;
      frames_since_hit = 0;
    end else begin
      tick   = v && !v_prev;
      v_prev = v;
      nh     = h && (m == M_PLAY);
      nhe    = he && (m == M_PLAY || m == M_INV);
      if (s) begin
        m = M_PLAY; hp = HP_MAX; vis = 1'b1; hit_p = 1'b0; heal_p = 1'b0;
      end else if (tick) begin
        if (m == M_PLAY) begin
          if (hit_p) begin
            if (hp <= 1) begin
              hp = 0; m = M_DEAD;
            end else begin
              hp = hp - 1; m = M_INV; frames_since_hit = 0; vis = 1'b0;
            end
          end else if (heal_p) hp = sat_heal(hp);
        end else if (m == M_INV) begin
          if (heal_p) hp = sat_heal(hp);
          frames_since_hit++;
          if (frames_since_hit == int'(INV_F)) begin
            m = M_PLAY; vis = 1'b1;
          end else begin
            vis = ((frames_since_hit / int'(BLK_F)) % 2) == 1;
          end
        end
        hit_p = nh; heal_p = nhe;
      end else begin
        hit_p = hit_p | nh; heal_p = heal_p | nhe;
      end
    end
    e.hp  = hp;
    e.low = (hp > 0) && (hp <= int'(LOW_HP));
    e.inv = (m == M_INV);
    e.vis = vis;
    e.go  = (m == M_DEAD);
    sb.push_back(e);
  endtask

  // One clock of stimulus: inputs change on the falling edge
  task automatic drive(input bit r, input bit v, input bit s, input bit h, input bit he);
    @(negedge clk);
    rst = r; bus.vblnk = v; bus.start = s; bus.hit = h; bus.heal = he;
    model_step(r, v, s, h, he);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (int'(bus.hp_out) != e.hp || bus.low_hp !== e.low || bus.invuln !== e.inv ||
            bus.sprite_vis !== e.vis || bus.game_over !== e.go) begin
          fails++;
          $display("FAIL scoreboard t=%0t: got hp=%0d low=%b inv=%b vis=%b over=%b, expected hp=%0d low=%b inv=%b vis=%b over=%b",
                   $time, bus.hp_out, bus.low_hp, bus.invuln, bus.sprite_vis, bus.game_over,
                   e.hp, e.low, e.inv, e.vis, e.go);
        end
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: 5 blank-low clocks with optional events, then the tick clock
  task automatic frame(input bit h, input bit he, input bit h_tick);
    drive(1, 0, 0, h, 0);
    drive(1, 0, 0, 0, he);
    drive(1, 0, 0, h, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, h, 0);
    drive(1, 1, 0, h_tick, 0);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 0);
  endtask

  initial begin
    int per, cnt;
    bit v;
    rst = 1'b0; bus.vblnk = 0; bus.start = 0; bus.hit = 0; bus.heal = 0;

    // Reset, then idle with ignored hits
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    frame(1, 1, 1);
    settle();
    check("idle_hp", int'(bus.hp_out), 0);
    check("idle_vis", int'(bus.sprite_vis), 1);
    check("idle_over", int'(bus.game_over), 0);

    // Start, three hits in one frame count once
    drive(1, 0, 1, 0, 0);
    frame(1, 0, 0);
    settle();
    check("hit_hp", int'(bus.hp_out), 8);
    check("hit_inv", int'(bus.invuln), 1);
    check("hit_vis", int'(bus.sprite_vis), 0);
    for (int i = 1; i < int'(INV_F); i++) begin
      frame(1, 0, 0);
      settle();
      if (i == 7) check("blink_pre", int'(bus.sprite_vis), 0);
      if (i == 8) check("blink_toggle", int'(bus.sprite_vis), 1);
    end
    check("inv_hold_hp", int'(bus.hp_out), 8);
    check("inv_hold", int'(bus.invuln), 1);
    frame(0, 0, 0);
    settle();
    check("inv_end", int'(bus.invuln), 0);
    check("inv_end_vis", int'(bus.sprite_vis), 1);

    // Heal saturation at the ceiling
    frame(0, 1, 0);
    frame(0, 1, 0);
    settle();
    check("heal_sat", int'(bus.hp_out), 9);

    // Walk down to 4, then hit+heal in one frame
    for (int i = 0; i < 5; i++) begin
      frame(1, 0, 0);
      quiet(int'(INV_F));
    end
    check("hp_four", int'(bus.hp_out), 4);
    frame(1, 1, 0);
    settle();
    check("hit_wins_hp", int'(bus.hp_out), 3);
    check("hit_wins_low", int'(bus.low_hp), 1);
    quiet(int'(INV_F));
    for (int i = 0; i < 2; i++) begin
      frame(1, 0, 0);
      quiet(int'(INV_F));
    end
    frame(1, 0, 0);
    settle();
    check("dead_hp", int'(bus.hp_out), 0);
    check("dead_over", int'(bus.game_over), 1);
    check("dead_low", int'(bus.low_hp), 0);

    // Restart from dead
    drive(1, 0, 1, 0, 0);
    settle();
    check("restart_hp", int'(bus.hp_out), 9);
    check("restart_over", int'(bus.game_over), 0);

    // Hit on the tick clock lands one frame later
    frame(0, 0, 1);
    settle();
    check("tick_hit_hold", int'(bus.hp_out), 9);
    frame(0, 0, 0);
    settle();
    check("tick_hit_next", int'(bus.hp_out), 8);

    // Async reset mid-invulnerability
    quiet(3);
    drive(0, 0, 0, 0, 0);
    settle();
    check("rst_hp", int'(bus.hp_out), 0);
    check("rst_inv", int'(bus.invuln), 0);
    check("rst_vis", int'(bus.sprite_vis), 1);

    // Randomized traffic with variable frame lengths
    per = 4; cnt = 0; v = 1'b0;
    drive(1, 0, 1, 0, 0);
    for (int c = 0; c < 20000; c++) begin
      cnt++;
      if (cnt >= per) begin
        cnt = 0;
        v   = ~v;
        per = v ? int'($urandom_range(1, 3)) : int'($urandom_range(2, 6));
      end
      drive($urandom_range(0, 3999) != 0, v, $urandom_range(0, 1999) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
    end
    drive(1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
